// File: rtl/hlm_sweep_pkg.sv
// Shared types and defaults for the truth-table sweeper.
package hlm_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_e;

  localparam int N_IN_DEF          = 4;
  localparam int N_VEC_DEF         = 2**N_IN_DEF;
  localparam int SETTLE_CYCLES_DEF = 8;
  localparam int CNT_W_DEF         = 8;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter; holds at zero and flags it.
module settle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = load_val;
    else if (en && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a logic block through every input vector, samples its output after a
// settle delay and compares the measured truth table against an expected one.
module truth_table_sweeper
  import hlm_sweep_pkg::*;
#(
  parameter int N_IN          = N_IN_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  localparam int N_VEC        = 2**N_IN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_VEC-1:0] expected,
  output logic [N_IN-1:0]  x_out,
  input  logic             s_in,
  output logic             busy,
  output logic             done,
  output logic [N_VEC-1:0] tt,
  output logic             match,
  output logic [N_VEC-1:0] mismatch
);

  sweep_state_e     state_q, state_d;
  logic [N_IN-1:0]  idx_q, idx_d;
  logic [N_VEC-1:0] exp_q, exp_d;
  logic [N_VEC-1:0] tt_q, tt_d;
  logic [N_VEC-1:0] mism_q, mism_d;
  logic             match_q, match_d;
  logic             tmr_load, tmr_en, tmr_zero;

  settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (CNT_W'(SETTLE_CYCLES - 1)),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    exp_d    = exp_q;
    tt_d     = tt_q;
    mism_d   = mism_q;
    match_d  = match_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // abort is deliberately ignored here so start always wins
        if (start) begin
          exp_d    = expected;
          tt_d     = '0;
          mism_d   = '0;
          match_d  = 1'b0;
          idx_d    = '0;
          tmr_load = 1'b1;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (abort)         state_d = IDLE;
        else if (tmr_zero) state_d = SAMPLE;
        else               tmr_en  = 1'b1;
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          tt_d[idx_q] = s_in;
          if (idx_q == N_IN'(N_VEC - 1)) begin
            // compare against the table including this last sample so the
            // result is already valid while done is high
            mism_d  = tt_d ^ exp_q;
            match_d = (tt_d == exp_q);
            state_d = DONE;
          end else begin
            idx_d    = idx_q + N_IN'(1);
            tmr_load = 1'b1;
            state_d  = SETTLE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      exp_q   <= '0;
      tt_q    <= '0;
      mism_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      mism_q  <= mism_d;
      match_q <= match_d;
    end
  end

  assign busy     = (state_q == SETTLE) || (state_q == SAMPLE);
  assign x_out    = busy ? idx_q : '0;
  assign done     = (state_q == DONE);
  assign tt       = tt_q;
  assign match    = match_q;
  assign mismatch = mism_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised self-checking bench: two sweepers (settle 2 and settle 1) driving
// a behavioural logic block with optional output delay.
module tb_truth_table_sweeper;

  localparam int SA = 2;
  localparam int SB = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt = 0;
  int err_cnt = 0;

  // instance A
  logic        start_a = 1'b0, abort_a = 1'b0;
  logic [15:0] exp_a = '0, tbl_a = '0;
  int          dly_a = 0;
  logic [3:0]  x_out_a;
  logic        s_in_a, busy_a, done_a, match_a, a_now, a_d1 = 1'b0, a_d2 = 1'b0;
  logic [15:0] tt_a, mism_a;

  // instance B: fixed 2-cycle delayed logic block
  logic        start_b = 1'b0;
  logic [15:0] exp_b = '0, tbl_b = '0;
  logic [3:0]  x_out_b;
  logic        s_in_b, busy_b, done_b, match_b, b_now, b_d1 = 1'b0, b_d2 = 1'b0;
  logic [15:0] tt_b, mism_b;

  assign a_now  = tbl_a[x_out_a];
  assign s_in_a = (dly_a == 0) ? a_now : (dly_a == 1) ? a_d1 : a_d2;
  assign b_now  = tbl_b[x_out_b];
  assign s_in_b = b_d2;

  always @(posedge clk) begin
    a_d1 <= a_now; a_d2 <= a_d1;
    b_d1 <= b_now; b_d2 <= b_d1;
  end

  truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(SA), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .expected(exp_a),
    .x_out(x_out_a), .s_in(s_in_a), .busy(busy_a), .done(done_a), .tt(tt_a),
    .match(match_a), .mismatch(mism_a)
  );

  truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(SB), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0), .expected(exp_b),
    .x_out(x_out_b), .s_in(s_in_b), .busy(busy_b), .done(done_b), .tt(tt_b),
    .match(match_b), .mismatch(mism_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Vector i is sampled s cycles after it first appears; a block with output
  // delay d therefore reports the vector that was on x_out d cycles earlier
  // (x_out sits at 0 before the sweep).
  function automatic logic [15:0] ref_tt(input logic [15:0] tbl, input int s, input int d);
    logic [15:0] r;
    int t, v;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      t = i * (s + 1) + s - d;
      v = (t < 0) ? 0 : t / (s + 1);
      r[i] = tbl[v];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"},     32'(x_out_a), 0);
    chk({tag, "_busy"},  32'(busy_a),  0);
    chk({tag, "_done"},  32'(done_a),  0);
    chk({tag, "_tt"},    32'(tt_a),    0);
    chk({tag, "_match"}, 32'(match_a), 0);
    chk({tag, "_mism"},  32'(mism_a),  0);
  endtask

  // Entered and left in an IDLE cycle, #1 after the edge.
  task automatic sweep_a(input logic [15:0] tbl, input logic [15:0] exp, input int dly,
                         input bit retrig, input bit hold);
    int n;
    logic [15:0] rtt, mask;
    n = 16 * (SA + 1);
    rtt = ref_tt(tbl, SA, dly);
    tbl_a = tbl; dly_a = dly; exp_a = exp; start_a = 1'b1;
    tick();
    if (!hold) start_a = 1'b0;
    for (int j = 0; j < n; j++) begin
      mask = 16'((32'd1 << (j / (SA + 1))) - 1);
      chk("busy",  32'(busy_a),  1);
      chk("x_out", 32'(x_out_a), 32'(j / (SA + 1)));
      chk("done_early",  32'(done_a),  0);
      chk("match_early", 32'(match_a), 0);
      chk("tt_partial",  32'(tt_a), 32'(rtt & mask));
      if (retrig && j == 10) begin start_a = 1'b1; exp_a = ~exp; end
      if (retrig && j == 11) begin start_a = 1'b0; exp_a = exp;  end
      if (retrig && j == 20) exp_a = ~exp;
      tick();
    end
    chk("done",     32'(done_a),  1);
    chk("busy_done", 32'(busy_a), 0);
    chk("x_done",   32'(x_out_a), 0);
    chk("tt",       32'(tt_a),    32'(rtt));
    chk("match",    32'(match_a), 32'(rtt == exp));
    chk("mismatch", 32'(mism_a),  32'(rtt ^ exp));
    tick();
    chk("done_pulse", 32'(done_a),  0);
    chk("busy_idle",  32'(busy_a),  0);
    chk("tt_hold",    32'(tt_a),    32'(rtt));
    chk("match_hold", 32'(match_a), 32'(rtt == exp));
    chk("mism_hold",  32'(mism_a),  32'(rtt ^ exp));
    exp_a = ~exp;
  endtask

  initial begin
    logic [15:0] t, e, r;
    int cyc;

    tick(); tick();
    chk_all_zero("rst");
    rst_n = 1'b1;
    tick();

    // directed sweeps
    sweep_a(16'hF547, 16'hF547, 0, 0, 0);
    sweep_a(16'hF547, 16'hF546, 0, 0, 0);
    sweep_a(16'hF547, 16'hF547, 1, 0, 0);

    // settle 1 with a 2-cycle-late block samples the previous vector
    tbl_b = 16'hF547; exp_b = 16'hF547; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cyc = 1;
    while (!done_b && cyc < 200) begin tick(); cyc++; end
    chk("b_latency", 32'(cyc), 33);
    r = ref_tt(16'hF547, SB, 2);
    chk("b_tt",      32'(tt_b),   32'(r));
    chk("b_mism",    32'(mism_b), 32'(r ^ 16'hF547));
    chk("b_mism_nz", 32'(mism_b != 0), 1);
    chk("b_match",   32'(match_b), 0);

    // abort while x_out = 5
    t = 16'($urandom); e = 16'($urandom);
    tbl_a = t; dly_a = 0; exp_a = e; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (5 * (SA + 1)) tick();
    chk("abort_x5", 32'(x_out_a), 5);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("abort_busy",  32'(busy_a),  0);
    chk("abort_x",     32'(x_out_a), 0);
    chk("abort_tt",    32'(tt_a),    32'(ref_tt(t, SA, 0) & 16'h001F));
    chk("abort_match", 32'(match_a), 0);
    for (int j = 0; j < 60; j++) begin
      chk("abort_no_done", 32'(done_a), 0);
      tick();
    end
    sweep_a(16'($urandom), 16'($urandom), 0, 0, 0);

    // start while busy must not restart or re-latch expected
    t = 16'($urandom);
    sweep_a(t, t, 0, 1, 0);

    // start held through DONE chains straight into a new sweep
    t = 16'($urandom);
    sweep_a(t, t ^ 16'h8000, 0, 0, 1);
    sweep_a(16'($urandom), 16'($urandom), 0, 0, 0);

    // random sweeps
    for (int k = 0; k < 4; k++) begin
      t = 16'($urandom);
      e = ($urandom_range(0, 1) == 1) ? t : t ^ (16'd1 << $urandom_range(0, 15));
      sweep_a(t, e, int'($urandom_range(0, 1)), 0, 0);
    end

    // reset in the middle of a sweep
    tbl_a = 16'($urandom); start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (20) begin exp_a = 16'($urandom); tick(); end
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    #2;
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("post_rst_busy", 32'(busy_a),  0);
      chk("post_rst_x",    32'(x_out_a), 0);
      chk("post_rst_tt",   32'(tt_a),    0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequences a 4-input combinational logic block through all 16 input vectors. For each vector it drives the block's inputs, waits a programmable settle time, then samples the single output. It assembles the measured truth table and compares it against an expected table. It sits between the test/config controller and one logic-circuit instance, and produces a pass/fail plus a per-vector mismatch mask.

Parameters:
N_IN, 4, number of logic-block inputs; vector count N_VEC = 2**N_IN (16).
SETTLE_CYCLES, 8, clock cycles each vector is held before sampling; legal range 1..255.
CNT_W, 8, settle-counter width; must satisfy 2**CNT_W > SETTLE_CYCLES.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
start  input  1  level; accepted only in IDLE; begins a sweep.
abort  input  1  level; terminates an active sweep.
expected  input  N_VEC  expected truth table; bit i = required output for vector i; sampled once on start acceptance.
x_out  output  N_IN  drives the logic-block inputs; x_out[3]=x_1 (MSB of vector index) down to x_out[0]=x_4.
s_in  input  1  logic-block output; same clock domain, no synchroniser.
busy  output  1  high from the cycle after start acceptance until the sweep ends.
done  output  1  one-cycle pulse when a full sweep completes (never on abort).
tt  output  N_VEC  measured truth table; bit i = s_in sampled for vector i.
match  output  1  valid from done; 1 when tt == latched expected.
mismatch  output  N_VEC  tt XOR latched expected; valid from done.

Behaviour:
- Reset values: x_out=0, busy=0, done=0, tt=0, match=0, mismatch=0, FSM=IDLE, vector index=0, settle count=0.
- FSM states:
  - IDLE: x_out=0. start=1 -> latch expected, clear tt/match/mismatch, idx=0 -> SETTLE.
  - SETTLE: x_out=idx. Counter loads SETTLE_CYCLES-1 on entry and decrements; at 0 -> SAMPLE.
  - SAMPLE: one cycle; tt[idx] <= s_in at the end of this cycle. If idx==N_VEC-1 -> DONE, else idx++ -> SETTLE.
  - DONE: one cycle; done=1, match/mismatch registered from final tt; busy=0 -> IDLE.
- Timing per vector: x_out is stable for exactly SETTLE_CYCLES+1 cycles (SETTLE plus SAMPLE); sampling occurs on the last of them.
- Latency: start accepted at edge k; x_out=0 and busy=1 from k+1; done high in cycle k+1+N_VEC*(SETTLE_CYCLES+1).
- tt updates one bit per SAMPLE, so partial progress is observable; match/mismatch stay 0 until DONE.
- tt, match and mismatch hold after DONE until the next accepted start.
- Boundary conditions:
  - start while busy: ignored; expected is not re-latched.
  - start held continuously: a new sweep is accepted in the IDLE cycle immediately following DONE.
  - abort in SETTLE or SAMPLE: next state IDLE, no done, partial tt retained, match=0, x_out returns to 0 the next cycle.
  - abort in IDLE or DONE: no effect, so the done pulse is never suppressed.
  - abort and start together in IDLE: start wins.
  - rst_n low at any time: immediate return to reset values, including mid-sweep.
  - Index is N_IN bits wide; it never wraps because DONE precedes increment past N_VEC-1.

Decomposition:
- Package hlm_sweep_pkg: state enum (IDLE, SETTLE, SAMPLE, DONE), N_IN_DEF=4, N_VEC_DEF=16, default SETTLE_CYCLES.
- One sub-module, settle_timer: loadable down-counter with load/zero flag, parameterised by CNT_W.
- FSM, index counter and result registers live in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-simulation with random inputs -> all outputs 0 immediately; stay 0 after release until start.
- Full sweep: SETTLE_CYCLES=2, DUT model with tt 16'hF547, expected=16'hF547, start pulse at edge k -> x_out steps 0..15, each held 3 cycles; done at k+49; tt=16'hF547, match=1, mismatch=0.
- Mismatch: same DUT model, expected=16'h F546 -> done at k+49; match=0, mismatch=16'h0001.
- Slow DUT: DUT output delayed 1 cycle through a register, SETTLE_CYCLES=2 -> tt=16'hF547. Same setup with SETTLE_CYCLES=1 and a 2-cycle delay -> mismatch nonzero.
- Abort: abort=1 while x_out=5 -> busy=0 and x_out=0 next cycle; done never pulses; tt bits 0..4 retained, match=0. A later start runs a full clean sweep.
- Re-trigger: start toggled while busy -> no restart and expected not re-latched. start held high through DONE -> new sweep begins; busy low for exactly the DONE cycle and the IDLE cycle.
